uart_recv_ctrl: RTL

//  UART receiver; consumes the serial line produced by the transmit-side controller/serializer (8N1, 9600 baud @ 100 MHz).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_recv_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Baud constants and receiver state encodings shared by the UART transmit and receive paths.
// UART_RECV_PARITY_EN (in uart_recv_ctrl) adds the PARITY state to the receive frame.
package uart_pkg;

  localparam int CYCLES_PER_BIT = 10416;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int DATA_BITS      = 8;
  localparam int CNT_W          = 14;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rxd line plus a one-flop delay for falling-edge detect.
// Flops reset to 1 so an idle line never looks like a start edge out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic rxd_meta;
  logic rxd_sync;
  logic rxd_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_d    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_d    <= rxd_sync;
    end
  end

  assign rxd_s = rxd_sync;
  assign fall  = rxd_d & ~rxd_sync;

endmodule

// File: rtl/uart_recv_ctrl.sv
// UART receiver (8N1, or 8E1 when UART_RECV_PARITY_EN is defined): start detect, mid-bit sampling,
// stop check, one-cycle valid / frame_err pulses.
//
//   state  | meaning
//   IDLE   | waiting for a falling edge on the synchronised line
//   START  | half a bit in, confirm start bit is still low
//   DATA   | sample one data bit per bit time, LSB first
//   PARITY | sample the even-parity bit (parity build only)
//   STOP   | sample stop bit, publish byte or flag framing error
module uart_recv_ctrl
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = uart_pkg::CYCLES_PER_BIT,
  parameter int HALF_BIT       = uart_pkg::HALF_BIT,
  parameter int DATA_BITS      = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RECV_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxd_s;
  logic                 fall;
  logic                 half_tc;
  logic                 bit_tc;
  logic                 last_bit;
  logic                 data_sample;
  logic                 stop_sample;
  logic                 frame_good;
  logic                 frame_bad;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  assign half_tc  = (clk_cnt == CNT_W'(HALF_BIT - 1));
  assign bit_tc   = (clk_cnt == CNT_W'(CYCLES_PER_BIT - 1));
  assign last_bit = (bit_cnt == BIT_W'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (fall)    state_nxt = START;
      START:  if (half_tc) state_nxt = rxd_s ? IDLE : DATA;
      DATA:   if (bit_tc && last_bit) begin
`ifdef UART_RECV_PARITY_EN
                state_nxt = PARITY;
`else
                state_nxt = STOP;
`endif
              end
      PARITY: if (bit_tc)  state_nxt = STOP;
      STOP:   if (bit_tc)  state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

`ifdef UART_RECV_PARITY_EN
  logic par_bit;
  logic par_sample;
  logic par_bad;
`endif

  always_comb begin
    busy        = (state != IDLE);
    data_sample = (state == DATA) && bit_tc;
    stop_sample = (state == STOP) && bit_tc;
    frame_bad   = stop_sample && !rxd_s;
`ifdef UART_RECV_PARITY_EN
    par_sample  = (state == PARITY) && bit_tc;
    par_bad     = stop_sample && ((^shreg) != par_bit);
    frame_good  = stop_sample && rxd_s && !par_bad;
`else
    frame_good  = stop_sample && rxd_s;
`endif
  end

  // Counter restarts on every state change so each state measures from its own entry edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE || state_nxt != state || bit_tc) clk_cnt <= '0;
      else                                                clk_cnt <= clk_cnt + CNT_W'(1);

      if (state == IDLE)    bit_cnt <= '0;
      else if (data_sample) bit_cnt <= bit_cnt + BIT_W'(1);

      if (data_sample) shreg[bit_cnt] <= rxd_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= frame_good;
      frame_err <= frame_bad;
      if (frame_good) data <= shreg;
    end
  end

`ifdef UART_RECV_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_sample) par_bit <= rxd_s;
      parity_err <= par_bad;
    end
  end
`endif

endmodule
